// File: rtl/ref_pkg.sv
// Constants and state encoding shared by the reference-window path
// (SRAM bank, window shifter, SAD PE array).
package ref_pkg;
  localparam int PIX_W    = 8;
  localparam int REF_ROWS = 23;
  localparam int REF_COLS = 23;
  localparam int WIN_W    = 16;
  localparam int DX_W     = 3;

  typedef enum logic [1:0] {IDLE, FILL, SLIDE} ref_state_e;
endpackage

// File: rtl/ref_col_counter.sv
// Column/band bookkeeping for the window shifter; state reflects the column
// accepted at the last edge (FILL for 0..WIN_W-2, SLIDE for the rest).
module ref_col_counter #(
  parameter int COLS  = ref_pkg::REF_COLS,
  parameter int WIN_W = ref_pkg::WIN_W,
  parameter int COL_W = $clog2(COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    next_line,
  input  logic                    sram_ready,
  output logic                    accept,
  output logic [COL_W-1:0]        col,
  output ref_pkg::ref_state_e     state,
  output logic [1:0]              band_idx
);
  import ref_pkg::*;

  ref_state_e       state_d;
  logic [COL_W-1:0] col_d;
  logic [1:0]       band_d;
  logic             band_end;

  // next_line wins over sram_ready: nothing is accepted that cycle
  assign accept   = sram_ready && !next_line;
  assign band_end = (col == COL_W'(COLS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      band_idx <= '0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      band_idx <= band_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    col_d   = '0;
    band_d  = '0;
    if (accept) begin
      state_d = (col < COL_W'(WIN_W-1)) ? FILL : SLIDE;
      col_d   = band_end ? '0 : col + 1'b1;
      band_d  = band_end ? band_idx + 2'd1 : band_idx;
    end
  end
endmodule

// File: rtl/ref_window_shifter.sv
// Shifts reference columns into a WIN_W-column window and tags each full
// window with its horizontal offset; one window per accepted column once full.
module ref_window_shifter #(
  parameter int PIX_W = ref_pkg::PIX_W,
  parameter int ROWS  = ref_pkg::REF_ROWS,
  parameter int COLS  = ref_pkg::REF_COLS,
  parameter int WIN_W = ref_pkg::WIN_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          next_line,
  input  logic                          sram_ready,
  input  logic [ROWS*PIX_W-1:0]         ref_col,
  output logic                          win_valid,
  output logic [ref_pkg::DX_W-1:0]      win_dx,
  output logic                          win_first,
  output logic                          win_last,
  output logic [1:0]                    band_idx,
  output logic [WIN_W*ROWS*PIX_W-1:0]   window
);
  import ref_pkg::*;

  localparam int COL_W = $clog2(COLS);

  logic                               accept;
  logic [COL_W-1:0]                   col;
  ref_state_e                         state;
  logic [WIN_W-1:0][ROWS*PIX_W-1:0]   win_q;
  logic                               in_slide;

  ref_col_counter #(.COLS(COLS), .WIN_W(WIN_W), .COL_W(COL_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .next_line  (next_line),
    .sram_ready (sram_ready),
    .accept     (accept),
    .col        (col),
    .state      (state),
    .band_idx   (band_idx)
  );

  assign in_slide  = (col >= COL_W'(WIN_W-1));
  assign win_valid = (state == SLIDE);
  assign window    = win_q;

  // Window is never cleared between bands; FILL overwrites it before the next valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '0;
      win_dx    <= '0;
      win_first <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_dx    <= '0;
      win_first <= 1'b0;
      win_last  <= 1'b0;
      if (accept) begin
        win_q <= {win_q[WIN_W-2:0], ref_col};
        if (in_slide) begin
          win_dx    <= DX_W'(col - COL_W'(WIN_W-1));
          win_first <= (col == COL_W'(WIN_W-1));
          win_last  <= (col == COL_W'(COLS-1));
        end
      end
    end
  end
endmodule

// File: doc/ref_window_shifter.md
# ref_window_shifter

Downstream neighbour of the reference line-buffer SRAM bank. Each cycle the SRAM bank presents one 23-pixel vertical reference column. This block shifts those columns into a 16-column × 23-row register window and tags each full window with its horizontal offset `dx` (0..7). It then hands the window to the SAD PE array, one candidate column position per cycle, without stalling the SRAM bank.

## Interface
Parameters:
- `PIX_W`, default 8: bits per pixel.
- `ROWS`, default 23: pixels per reference column (16 block rows + 7 vertical search).
- `COLS`, default 23: columns per band.
- `WIN_W`, default 16: window width in columns; `COLS-WIN_W+1` = 8 horizontal offsets.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `next_line`  in  1: synchronous abort/restart, same pulse that restarts the SRAM bank.
- `sram_ready`  in  1: SRAM bank output valid. The first cycle it is high, `ref_col` carries column 0 of a band.
- `ref_col`  in  ROWS*PIX_W (184): one column, top pixel in the MSBs.
- `win_valid`  out  1: `window`/`win_dx` valid this cycle.
- `win_dx`  out  3: horizontal offset of the window's oldest column, 0..7.
- `win_first`  out  1: high with `win_dx`==0.
- `win_last`  out  1: high with `win_dx`==7.
- `band_idx`  out  2: band counter since line start, wraps mod 4.
- `window`  out  WIN_W*ROWS*PIX_W (2944): oldest column in the MSB slice, newest in the LSB slice.

## Operation
- Column counter `col` (5 b) accepts a column in every cycle where `sram_ready`=1. It starts at 0, increments to COLS-1 (22), then wraps to 0 for the next band with no bubble.
- On each accepted column: `window <= {window[WIN_W-1 slices below MSB], ref_col}`, i.e. shift left by one column and insert the new column at the LSB slice.
- States:
  - IDLE: entered on reset, `next_line`, or `sram_ready`=0.
  - FILL: `col` 0..14 accepted, no output.
  - SLIDE: `col` 15..22 accepted; each acceptance produces one valid window.
- Transitions:
  - SLIDE with `col`=22 goes to FILL when `sram_ready` stays high.
  - Window contents from the previous band are not cleared; they are overwritten before the next valid window.
- `win_dx` = `col`−15 of the accepted column.
- `band_idx` increments on acceptance of `col`=22, wraps 3→0, and clears on `next_line`/IDLE entry.
- `sram_ready` falling mid-band aborts the band:
  - `col` and `win_valid` are cleared.
  - Resumption restarts at column 0.
- `next_line` has priority over `sram_ready` in the same cycle: no column is accepted, and the block goes to IDLE.
- Async `rst` mid-SLIDE clears everything immediately, including `win_valid`.

## Timing
- Reset values are all 0: `win_valid`, `win_dx`, `win_first`, `win_last`, `band_idx`, `window`, `col`, state=IDLE.
- All outputs are registered. Latency is 1 cycle from column acceptance to output.
  - Column 15 accepted at edge N gives `win_valid`=1, `win_dx`=0, `win_first`=1 in the cycle after edge N.
  - Column 22 accepted gives `win_dx`=7, `win_last`=1 one cycle later.
- Per band: 15 cycles with `win_valid` low, then 8 consecutive cycles high. The steady-state period is 23 cycles.
- There is no back-pressure. The consumer must accept every valid window in the cycle presented.
- `next_line` asserted at edge N means the outputs after edge N have `win_valid`=0 and `band_idx`=0.

## Structure
- Shared package `ref_pkg` holds:
  - constants `PIX_W`, `REF_ROWS`, `REF_COLS`, `WIN_W`, `DX_W`=3;
  - state enum `{IDLE, FILL, SLIDE}`.
- The SRAM bank and the PE array import the same constants.
- Single module. The column/band counter with state logic may be split into sub-module `ref_col_counter` (outputs `col`, state, `band_idx`). The wide shift register stays in `ref_window_shifter`.

## Test plan
- Cold start:
  - Stimulus: `sram_ready` rises; pixel(row r, col c) = {c[3:0], r[3:0]}.
  - Response: `win_valid` first high one cycle after the 16th column, with `win_dx`=0 and `win_first`=1. The window MSB slice holds col 0 and the LSB slice holds col 15.
- Slide:
  - Stimulus: continue feeding columns.
  - Response: eight consecutive valid cycles with `win_dx`=0..7. The last one has `win_last`=1, `band_idx` going 0→1, and a window holding cols 7..22.
- Band wrap:
  - Stimulus: continuous `sram_ready` across 2 bands.
  - Response: exactly 15 invalid cycles between bands, second band windows correct, `band_idx`=2 after band 2.
- `next_line` at `win_dx`=3:
  - Response: next cycle `win_valid`=0 and `band_idx`=0. A restart re-fills from col 0 and gives the first valid at `dx`=0 after 16 columns.
- `sram_ready` dropped at col 10:
  - Response: no valid window. On restart, column numbering begins at 0.
- Async `rst` asserted mid-SLIDE (not on a clock edge):
  - Response: all outputs 0 immediately. After release, behaves as cold start.
